// File: rtl/gerenciador_ataque.sv
// Attack manager for the naval-battle game.
// Holds the 5x7 revealed-hit matrix, reveals one cell per confirmed shot,
// reports hit/miss on the status LEDs and counts lives down on every miss.

// 3-to-8 one-hot decoder used for both the row and the column selection.
module decodificador_3bits (
    input  logic [2:0] entrada,
    output logic [7:0] saida
);

    // Raise exactly the output bit addressed by the input code.
    always_comb begin
        saida          = 8'b0000_0000;
        saida[entrada] = 1'b1;
    end

endmodule

// 7-bit equality comparator, one per matrix column.
module comparador_de_igualdade (
    input  logic [6:0] a,
    input  logic [6:0] b,
    output logic       igual
);

    // Flag when both column words are identical.
    always_comb begin
        igual = (a == b);
    end

endmodule

// Life counter: starts at 3, loses one life per miss, saturates at 0.
module contador_vida (
    input  logic       clock,
    input  logic       enable,
    input  logic       decrementa,
    output logic [1:0] vida
);

    logic [1:0] vida_r;

    // Saturating down-counter; a miss with no lives left keeps it at 0.
    always_ff @(posedge clock or negedge enable) begin
        if (!enable) begin
            vida_r <= 2'd3;
        end else if (decrementa && (vida_r != 2'd0)) begin
            vida_r <= vida_r - 2'd1;
        end else begin
            vida_r <= vida_r;
        end
    end

    assign vida = vida_r;

endmodule

module gerenciador_ataque (
    input  logic       clock,
    input  logic       enable,
    input  logic [2:0] coordColuna,
    input  logic [2:0] coordLinha,
    input  logic       confirmar,
    input  logic [6:0] mapa0,
    input  logic [6:0] mapa1,
    input  logic [6:0] mapa2,
    input  logic [6:0] mapa3,
    input  logic [6:0] mapa4,
    output logic [6:0] matriz0,
    output logic [6:0] matriz1,
    output logic [6:0] matriz2,
    output logic [6:0] matriz3,
    output logic [6:0] matriz4,
    output logic       LED_R,
    output logic       LED_G,
    output logic       LED_B,
    output logic [1:0] vida
);

    logic [4:0][6:0] matriz_r;
    logic [4:0][6:0] mapa_s;
    logic [4:0][6:0] candidato_s;
    logic [4:0][6:0] mascara_s;
    logic [4:0]      iguais_s;
    logic [7:0]      linha_oh_s;
    logic [7:0]      coluna_oh_s;
    logic            selecao_valida_s;
    logic            confirmar_ant_r;
    logic            ativo_r;
    logic            evento_s;
    logic            acerto_s;
    logic            erro_s;
    logic            led_r_r;
    logic            led_g_r;

    assign mapa_s = {mapa4, mapa3, mapa2, mapa1, mapa0};

    decodificador_3bits u_dec_linha (
        .entrada (coordLinha),
        .saida   (linha_oh_s)
    );

    decodificador_3bits u_dec_coluna (
        .entrada (coordColuna),
        .saida   (coluna_oh_s)
    );

    // Row 7 and columns 5..7 address no cell: the candidate stays equal to
    // the current matrix, which the compare below turns into a miss.
    always_comb begin
        selecao_valida_s = ~linha_oh_s[7] & ~(|coluna_oh_s[7:5]);
    end

    // Build the candidate matrix: only the selected cell takes the map bit.
    always_comb begin
        mascara_s   = 35'd0;
        candidato_s = 35'd0;
        for (int c = 0; c < 5; c++) begin
            mascara_s[c]   = linha_oh_s[6:0] & {7{coluna_oh_s[c] & selecao_valida_s}};
            candidato_s[c] = (matriz_r[c] & ~mascara_s[c]) | (mapa_s[c] & mascara_s[c]);
        end
    end

    for (genvar c = 0; c < 5; c++) begin : g_comparador
        comparador_de_igualdade u_cmp (
            .a     (candidato_s[c]),
            .b     (matriz_r[c]),
            .igual (iguais_s[c])
        );
    end

    // A shot is a hit only when it reveals a new ship cell somewhere.
    always_comb begin
        acerto_s = ~(&iguais_s);
        erro_s   = evento_s & ~acerto_s;
    end

    // The first edge after reset release only arms the block, so a button
    // already held at release cannot fire; it must be released and pressed.
    always_ff @(posedge clock or negedge enable) begin
        if (!enable) begin
            ativo_r <= 1'b0;
        end else begin
            ativo_r <= 1'b1;
        end
    end

    // Remember the previous button level for rising-edge detection.
    always_ff @(posedge clock or negedge enable) begin
        if (!enable) begin
            confirmar_ant_r <= 1'b0;
        end else begin
            confirmar_ant_r <= confirmar;
        end
    end

    // One event per press, no matter how long the button is held.
    always_comb begin
        evento_s = ativo_r & confirmar & ~confirmar_ant_r;
    end

    // Commit the candidate matrix on each confirmed shot.
    always_ff @(posedge clock or negedge enable) begin
        if (!enable) begin
            matriz_r <= 35'd0;
        end else if (evento_s) begin
            matriz_r <= candidato_s;
        end else begin
            matriz_r <= matriz_r;
        end
    end

    // Status LEDs report the outcome of the most recent shot.
    always_ff @(posedge clock or negedge enable) begin
        if (!enable) begin
            led_r_r <= 1'b0;
            led_g_r <= 1'b0;
        end else if (evento_s) begin
            led_r_r <= ~acerto_s;
            led_g_r <= acerto_s;
        end else begin
            led_r_r <= led_r_r;
            led_g_r <= led_g_r;
        end
    end

    contador_vida u_vida (
        .clock      (clock),
        .enable     (enable),
        .decrementa (erro_s),
        .vida       (vida)
    );

    assign matriz0 = matriz_r[0];
    assign matriz1 = matriz_r[1];
    assign matriz2 = matriz_r[2];
    assign matriz3 = matriz_r[3];
    assign matriz4 = matriz_r[4];
    assign LED_R   = led_r_r;
    assign LED_G   = led_g_r;
    assign LED_B   = 1'b0;

endmodule

// File: tb/tb_gerenciador_ataque.sv
// Testbench for gerenciador_ataque: directed table, multi-cycle corner
// sequences and randomized shots checked against a behavioural game model.
`timescale 1ns/1ps

module tb_gerenciador_ataque;

    logic       clock;
    logic       enable;
    logic [2:0] coordColuna;
    logic [2:0] coordLinha;
    logic       confirmar;
    logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
    logic [6:0] matriz0, matriz1, matriz2, matriz3, matriz4;
    logic       LED_R, LED_G, LED_B;
    logic [1:0] vida;

    int errors = 0;
    int checks = 0;

    // Behavioural model: plain arrays of map/hit cells and an integer life count.
    int model_map  [5][7];
    int model_hits [5][7];
    int model_lives;
    int model_r;
    int model_g;

    gerenciador_ataque dut (
        .clock       (clock),
        .enable      (enable),
        .coordColuna (coordColuna),
        .coordLinha  (coordLinha),
        .confirmar   (confirmar),
        .mapa0       (mapa0),
        .mapa1       (mapa1),
        .mapa2       (mapa2),
        .mapa3       (mapa3),
        .mapa4       (mapa4),
        .matriz0     (matriz0),
        .matriz1     (matriz1),
        .matriz2     (matriz2),
        .matriz3     (matriz3),
        .matriz4     (matriz4),
        .LED_R       (LED_R),
        .LED_G       (LED_G),
        .LED_B       (LED_B),
        .vida        (vida)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  col;
        logic [2:0]  row;
        logic [34:0] exp_m;
        logic        exp_r;
        logic        exp_g;
        logic [1:0]  exp_v;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [34:0] actual_m();
        return {matriz4, matriz3, matriz2, matriz1, matriz0};
    endfunction

    task automatic check_all(input string name, input logic [34:0] em,
                             input logic er, input logic eg, input logic [1:0] ev);
        checks++;
        if (actual_m() !== em) begin
            errors++;
            $display("FAIL %s matriz: got %h expected %h", name, actual_m(), em);
        end
        checks++;
        if (LED_R !== er) begin
            errors++;
            $display("FAIL %s LED_R: got %b expected %b", name, LED_R, er);
        end
        checks++;
        if (LED_G !== eg) begin
            errors++;
            $display("FAIL %s LED_G: got %b expected %b", name, LED_G, eg);
        end
        checks++;
        if (LED_B !== 1'b0) begin
            errors++;
            $display("FAIL %s LED_B: got %b expected 0", name, LED_B);
        end
        checks++;
        if (vida !== ev) begin
            errors++;
            $display("FAIL %s vida: got %0d expected %0d", name, vida, ev);
        end
    endtask

    task automatic set_maps(input logic [6:0] m0, input logic [6:0] m1, input logic [6:0] m2,
                            input logic [6:0] m3, input logic [6:0] m4);
        logic [6:0] w [5];
        mapa0 = m0; mapa1 = m1; mapa2 = m2; mapa3 = m3; mapa4 = m4;
        w[0] = m0; w[1] = m1; w[2] = m2; w[3] = m3; w[4] = m4;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 7; r++)
                model_map[c][r] = int'(w[c][r]);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 7; r++)
                model_hits[c][r] = 0;
        model_lives = 3;
        model_r = 0;
        model_g = 0;
    endtask

    // A shot hits only if it lands on the board, on a ship, not yet revealed.
    task automatic model_fire(input int c, input int r);
        if (c < 5 && r < 7 && model_map[c][r] == 1 && model_hits[c][r] == 0) begin
            model_hits[c][r] = 1;
            model_r = 0;
            model_g = 1;
        end else begin
            model_r = 1;
            model_g = 0;
            if (model_lives > 0) model_lives = model_lives - 1;
        end
    endtask

    function automatic logic [34:0] model_m();
        logic [34:0] v;
        v = 35'd0;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 7; r++)
                if (model_hits[c][r] == 1) v[c*7 + r] = 1'b1;
        return v;
    endfunction

    task automatic check_model(input string name);
        check_all(name, model_m(), model_r[0], model_g[0], 2'(model_lives));
    endtask

    // Reset pulse aligned to negedges; leaves one arming edge before returning.
    task automatic do_reset();
        @(negedge clock);
        enable    = 1'b0;
        confirmar = 1'b0;
        @(negedge clock);
        enable = 1'b1;
        @(negedge clock);
        model_reset();
    endtask

    // Press for 'hold' cycles (coords scrambled after the event edge), then
    // release for 'gap' cycles.
    task automatic fire(input logic [2:0] c, input logic [2:0] r, input int hold, input int gap);
        @(negedge clock);
        coordColuna = c;
        coordLinha  = r;
        confirmar   = 1'b1;
        for (int i = 1; i < hold; i++) begin
            @(negedge clock);
            coordColuna = 3'($urandom);
            coordLinha  = 3'($urandom);
        end
        @(negedge clock);
        confirmar = 1'b0;
        for (int i = 1; i < gap; i++) @(negedge clock);
    endtask

    initial begin
        logic [34:0] m_a, m_b, m_c;
        enable      = 1'b0;
        confirmar   = 1'b0;
        coordColuna = 3'd0;
        coordLinha  = 3'd0;
        set_maps(7'b1110001, 7'b0100000, 7'b0000000, 7'b0000000, 7'b1110000);
        model_reset();

        m_a = {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000001};
        m_b = {7'b0000000, 7'b0000000, 7'b0000000, 7'b0100000, 7'b0000001};
        m_c = {7'b1000000, 7'b0000000, 7'b0000000, 7'b0100000, 7'b0000001};
        vecs[0] = '{3'd0, 3'd0, m_a, 1'b0, 1'b1, 2'd3};
        vecs[1] = '{3'd0, 3'd1, m_a, 1'b1, 1'b0, 2'd2};
        vecs[2] = '{3'd1, 3'd5, m_b, 1'b0, 1'b1, 2'd2};
        vecs[3] = '{3'd3, 3'd5, m_b, 1'b1, 1'b0, 2'd1};
        vecs[4] = '{3'd4, 3'd6, m_c, 1'b0, 1'b1, 2'd1};
        vecs[5] = '{3'd0, 3'd0, m_c, 1'b1, 1'b0, 2'd0};
        vecs[6] = '{3'd5, 3'd0, m_c, 1'b1, 1'b0, 2'd0};
        vecs[7] = '{3'd0, 3'd7, m_c, 1'b1, 1'b0, 2'd0};

        repeat (2) @(negedge clock);
        #1;
        check_all("reset_state", 35'd0, 1'b0, 1'b0, 2'd3);
        @(negedge clock);
        enable = 1'b1;
        @(negedge clock);

        // Scenarios 1-3: directed table from reset.
        for (int i = 0; i < 8; i++) begin
            fire(vecs[i].col, vecs[i].row, 1, 1);
            check_all($sformatf("table_%0d", i), vecs[i].exp_m, vecs[i].exp_r,
                      vecs[i].exp_g, vecs[i].exp_v);
        end

        // Outputs hold while idle even if coordinates wander.
        coordColuna = 3'd4;
        coordLinha  = 3'd4;
        repeat (3) @(negedge clock);
        check_all("idle_hold", m_c, 1'b1, 1'b0, 2'd0);

        // Scenario 4: button held 5 cycles gives exactly one miss.
        do_reset();
        @(negedge clock);
        coordColuna = 3'd0;
        coordLinha  = 3'd1;
        confirmar   = 1'b1;
        repeat (3) @(negedge clock);
        check_all("held_mid", 35'd0, 1'b1, 1'b0, 2'd2);
        repeat (2) @(negedge clock);
        confirmar = 1'b0;
        @(negedge clock);
        check_all("held_end", 35'd0, 1'b1, 1'b0, 2'd2);

        // Scenario 5: asynchronous reset between edges, then a fresh hit.
        fire(3'd0, 3'd0, 1, 1);
        check_all("pre_reset_hit", m_a, 1'b0, 1'b1, 2'd2);
        @(negedge clock);
        #2 enable = 1'b0;
        #1 check_all("async_reset", 35'd0, 1'b0, 1'b0, 2'd3);
        #1 enable = 1'b1;
        @(negedge clock);
        fire(3'd0, 3'd0, 1, 1);
        check_all("post_reset_hit", m_a, 1'b0, 1'b1, 2'd3);

        // Scenario 6: button held through reset release fires nothing.
        @(negedge clock);
        enable      = 1'b0;
        coordColuna = 3'd0;
        coordLinha  = 3'd0;
        confirmar   = 1'b1;
        @(negedge clock);
        enable = 1'b1;
        repeat (3) @(negedge clock);
        check_all("held_at_release", 35'd0, 1'b0, 1'b0, 2'd3);
        confirmar = 1'b0;
        @(negedge clock);
        fire(3'd0, 3'd0, 1, 1);
        check_all("repress_after_release", m_a, 1'b0, 1'b1, 2'd3);

        // Randomized rounds against the behavioural model.
        for (int round = 0; round < 8; round++) begin
            set_maps(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
            do_reset();
            for (int s = 0; s < 25; s++) begin
                logic [2:0] c, r;
                c = (($urandom % 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 4));
                r = 3'($urandom);
                model_fire(int'(c), int'(r));
                fire(c, r, int'($urandom_range(1, 3)), int'($urandom_range(1, 2)));
                check_model($sformatf("rand_r%0d_s%0d", round, s));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
